// File: rtl/elgamal_pkg.sv
// elgamal_pkg: shared definitions for the ElGamal datapath blocks.
//   PROD_W_DEF / MOD_W_DEF : default product and modulus widths
//   state_e                : FSM encoding for the sequential modular reducer
package elgamal_pkg;

   localparam int unsigned PROD_W_DEF = 64;
   localparam int unsigned MOD_W_DEF  = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mod_sub_step.sv
// mod_sub_step: one step of bit-serial restoring reduction (purely combinational).
//   r      in  MOD_W    current partial remainder (always < p)
//   in_bit in  1        next product bit, MSB first
//   p      in  MOD_W    modulus
//   r_next out MOD_W+1  t = {r, in_bit}; t - p when t >= p, else t
module mod_sub_step #(
   parameter int unsigned MOD_W = 32
) (
   input  logic [MOD_W-1:0] r,
   input  logic             in_bit,
   input  logic [MOD_W-1:0] p,
   output logic [MOD_W:0]   r_next
);

   logic [MOD_W:0] t;
   logic [MOD_W:0] p_ext;

   always_comb begin
      t      = {r, in_bit};
      p_ext  = {1'b0, p};
      // r < p on entry, so t < 2p and the difference never wraps.
      r_next = (t >= p_ext) ? (t - p_ext) : t;
   end

endmodule

// File: rtl/mod_reduce_64.sv
// mod_reduce_64: sequential modular reducer, product mod p, one conditional
// subtract per clock (64 iterations for a 64-bit product).
//   clk, rst            clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready  product input handshake
//   mod_p               modulus, captured together with s_tdata
//   m_tdata/m_tvalid/m_tready  residue output handshake
//   m_terr              modulus-zero flag (only with MOD_REDUCE_ERR_EN)
// Optional feature: define MOD_REDUCE_ERR_EN to flag p==0 as an error and
// bypass the iterations; otherwise p==0 yields s_tdata[MOD_W-1:0].
module mod_reduce_64
   import elgamal_pkg::*;
#(
   parameter int unsigned PROD_W = PROD_W_DEF,
   parameter int unsigned MOD_W  = MOD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PROD_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic [MOD_W-1:0]  mod_p,
   output logic [MOD_W-1:0]  m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready
`ifdef MOD_REDUCE_ERR_EN
   ,
   output logic              m_terr
`endif
);

   localparam int unsigned CNT_W = (PROD_W > 1) ? $clog2(PROD_W) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(PROD_W - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PROD_W-1:0] q_q, q_d;
   logic [MOD_W-1:0]  p_q, p_d;
   logic [MOD_W:0]    r_q, r_d;
   logic [MOD_W:0]    step_r;

   // The remainder MSB only exists to hold t before the subtract; the stored
   // value is always < p, so it is never consumed.
   logic unused_r_msb;
   assign unused_r_msb = r_q[MOD_W];

   mod_sub_step #(
      .MOD_W (MOD_W)
   ) u_step (
      .r      (r_q[MOD_W-1:0]),
      .in_bit (q_q[cnt_q]),
      .p      (p_q),
      .r_next (step_r)
   );

`ifdef MOD_REDUCE_ERR_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      p_d     = p_q;
      r_d     = r_q;
`ifdef MOD_REDUCE_ERR_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (s_tvalid) begin
               q_d     = s_tdata;
               p_d     = mod_p;
               r_d     = '0;
               cnt_d   = CNT_INIT;
               state_d = ST_RUN;
`ifdef MOD_REDUCE_ERR_EN
               // Zero modulus: skip the iterations, report 0 with the flag.
               if (mod_p == '0) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end
`endif
            end
         end
         ST_RUN: begin
            r_d = step_r;
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            if (m_tready) begin
               state_d = ST_IDLE;
`ifdef MOD_REDUCE_ERR_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         p_q     <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         p_q     <= p_d;
         r_q     <= r_d;
      end
   end

`ifdef MOD_REDUCE_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign m_terr = err_q;
`endif

   assign s_tready = (state_q == ST_IDLE);
   assign m_tvalid = (state_q == ST_DONE);
   // Gate the residue so m_tdata reads 0 whenever no result is presented.
   assign m_tdata  = m_tvalid ? r_q[MOD_W-1:0] : '0;

endmodule

// File: tb/tb_mod_reduce_64.sv
// tb_mod_reduce_64: directed vectors with a scoreboard queue; the stimulus
// process pushes expected residues, a monitor pops them on each handshake.
// Latency is counted in clock edges including the acceptance edge.
module tb_mod_reduce_64;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] mod_p;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
`ifdef MOD_REDUCE_ERR_EN
   logic        m_terr;
`endif

   mod_reduce_64 dut (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .mod_p    (mod_p),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready)
`ifdef MOD_REDUCE_ERR_EN
      ,
      .m_terr   (m_terr)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_vec      = 0;
   int   n_miss     = 0;
   int   cyc        = 0;
   int   valid_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: samples shortly after the falling edge so same-edge drives settle.
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (m_tvalid === 1'b1) valid_seen++;
      if (rst === 1'b0 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_result: got %0h expected none", m_tdata);
         end else begin
            e = sb.pop_front();
            chk("m_tdata", {32'd0, m_tdata}, {32'd0, e.data});
`ifdef MOD_REDUCE_ERR_EN
            chk("m_terr", {63'd0, m_terr}, {63'd0, e.err});
`endif
         end
      end
   end

   // Call at a falling edge. Returns the cycle count just after acceptance.
   task automatic send(input logic [63:0] d, input logic [31:0] p, input logic [31:0] exp_d,
                       input logic exp_e, input bit push, output int acc);
      int n = 0;
      while (!s_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_tready) chk("s_tready_wait", {63'd0, s_tready}, 64'd1);
      s_tdata  = d;
      mod_p    = p;
      s_tvalid = 1'b1;
      if (push) sb.push_back('{err: exp_e, data: exp_d});
      @(posedge clk);
      #1;
      acc      = cyc;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      mod_p    = 32'hDEAD_BEEF;  // later modulus changes must not matter
   endtask

   // Call just after the acceptance edge; returns at the falling edge where valid is seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      @(negedge clk);
      while (!m_tvalid && lat < 200) begin
         lat++;
         @(negedge clk);
      end
      chk("m_tvalid_rise", {63'd0, m_tvalid}, 64'd1);
   endtask

   initial begin
      #100_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [63:0] d;
      logic [31:0] p;
      logic [31:0] r;
      string       name;
   } vec_t;

   initial begin
      vec_t vecs[4];
      int   acc, lat, c0;
      exp_t zero_exp;

      vecs[0] = '{64'd100, 32'd7, 32'd2, "100_mod_7"};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB, 32'd24, "max_mod_big"};
      vecs[2] = '{64'd5, 32'd7, 32'd5, "prod_lt_p"};
      vecs[3] = '{64'h1234_5678_9ABC_DEF0, 32'd1, 32'd0, "p_eq_1"};

      rst      = 1'b1;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      mod_p    = '0;
      m_tready = 1'b1;
      #1;
      chk("reset_s_tready", {63'd0, s_tready}, 64'd1);
      chk("reset_m_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("reset_m_tdata", {32'd0, m_tdata}, 64'd0);
`ifdef MOD_REDUCE_ERR_EN
      chk("reset_m_terr", {63'd0, m_terr}, 64'd0);
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic vectors; the first also checks latency and s_tready during RUN.
      for (int i = 0; i < 4; i++) begin
         send(vecs[i].d, vecs[i].p, vecs[i].r, 1'b0, 1'b1, acc);
         if (i == 0) chk("s_tready_busy", {63'd0, s_tready}, 64'd0);
         wait_valid(lat);
         if (i == 0) chk("latency", 64'(lat), 64'd65);
      end

      // Output stall for 10 cycles, then back-to-back second product.
      @(negedge clk);
      m_tready = 1'b0;
      send(64'd200, 32'd9, 32'd2, 1'b0, 1'b1, acc);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_m_tvalid", {63'd0, m_tvalid}, 64'd1);
         chk("stall_m_tdata", {32'd0, m_tdata}, 64'd2);
         chk("stall_s_tready", {63'd0, s_tready}, 64'd0);
      end
      c0       = cyc;
      m_tready = 1'b1;
      send(64'd77, 32'd10, 32'd7, 1'b0, 1'b1, acc);
      chk("b2b_accept_cycle", 64'(acc), 64'(c0 + 2));
      wait_valid(lat);

      // Reset in the middle of an iteration run aborts without a result.
      @(negedge clk);
      send(64'h0123_4567_89AB_CDEF, 32'd1000, 32'd0, 1'b0, 1'b0, acc);
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_s_tready", {63'd0, s_tready}, 64'd1);
      chk("abort_m_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("abort_m_tdata", {32'd0, m_tdata}, 64'd0);
      @(negedge clk);
      rst        = 1'b0;
      valid_seen = 0;
      repeat (80) @(negedge clk);
      chk("abort_no_valid", 64'(valid_seen), 64'd0);
      send(64'd1000, 32'd13, 32'd12, 1'b0, 1'b1, acc);
      wait_valid(lat);

      // Zero modulus.
      @(negedge clk);
`ifdef MOD_REDUCE_ERR_EN
      send(64'hAAAA_BBBB_CCCC_DDDD, 32'd0, 32'd0, 1'b1, 1'b1, acc);
      wait_valid(lat);
      chk("p0_latency", 64'(lat), 64'd1);
      @(negedge clk);
      chk("p0_terr_cleared", {63'd0, m_terr}, 64'd0);
`else
      send(64'hAAAA_BBBB_CCCC_DDDD, 32'd0, 32'hCCCC_DDDD, 1'b0, 1'b1, acc);
      wait_valid(lat);
      chk("p0_latency", 64'(lat), 64'd65);
`endif

      repeat (4) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      zero_exp = '0;
      if (sb.size() != 0) zero_exp = sb[0];
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
